// File: rtl/cpu_bus_bridge_pkg.sv
// cpu_bus_bridge_pkg: shared definitions for the host-to-CPU-bus bridge.
// Holds the bridge state enum, the parked idle address, the downstream
// address map and the legality checks applied to accepted requests.
package cpu_bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RSP
    } state_e;

    // Parked address while no access is in flight; unmapped so no select asserts.
    localparam logic [17:0] IDLE_ADR = 18'h3F000;

    // Writable 4 KB pages (ADR[17:12]).
    localparam logic [5:0] SRAM_LAST  = 6'h2D;
    localparam logic [5:0] BIAS_PAGE  = 6'h2E;
    localparam logic [5:0] IMAGE_PAGE = 6'h30;

    // Readable result words.
    localparam logic [17:0] RESULT_BASE  = 18'h31000;
    localparam int          RESULT_COUNT = 46;
    localparam logic [17:0] RESULT_LAST  = RESULT_BASE + 18'(4 * (RESULT_COUNT - 1));

    function automatic logic is_legal_wr(input logic [17:0] adr);
        return (adr[1:0] == 2'b00) &&
               ((adr[17:12] <= SRAM_LAST) || (adr[17:12] == BIAS_PAGE) ||
                (adr[17:12] == IMAGE_PAGE));
    endfunction

    function automatic logic is_legal_rd(input logic [17:0] adr);
        return (adr[1:0] == 2'b00) && (adr >= RESULT_BASE) && (adr <= RESULT_LAST);
    endfunction

endpackage

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: single-request host bridge onto a strobed CPU-style bus.
// Ports:
//   CLK, RESET_X               rising-edge clock, async active-low reset
//   REQ_VALID/READY/WRITE      host request handshake and direction
//   REQ_ADR, REQ_WDATA         host byte address and write data
//   RSP_VALID/RDATA/ERR        one-cycle completion with read data / reject flag
//   CPU_WR, CPU_RD             downstream write/read strobes
//   CPU_ADR, CPU_WDATA         downstream address and write data
//   CPU_RDATA                  downstream read data, valid RD_LAT cycles after address
// All outputs come straight from flops; each is computed from the next state.
module cpu_bus_bridge
    import cpu_bus_bridge_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RESET_X,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [17:0] REQ_ADR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        CPU_WR,
    output logic        CPU_RD,
    output logic [17:0] CPU_ADR,
    output logic [31:0] CPU_WDATA,
    input  logic [31:0] CPU_RDATA
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        cpu_wr_q, cpu_wr_d;
    logic        cpu_rd_q, cpu_rd_d;
    logic [17:0] cpu_adr_q, cpu_adr_d;
    logic [31:0] cpu_wdata_q, cpu_wdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: if (REQ_VALID && req_ready_q)
                state_d = REQ_WRITE ? (is_legal_wr(REQ_ADR) ? WR : RSP)
                                    : (is_legal_rd(REQ_ADR) ? RD : RSP);
            WR:   state_d = RSP;
            RD: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(RD_LAT))
                    state_d = RSP;
            end
            RSP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = state_d == IDLE;
        cpu_wr_d    = state_d == WR;
        cpu_rd_d    = state_d == RD;
        // The request fields are only sampled on the accept cycle; afterwards
        // the address lives in cpu_adr_q and the data in cpu_wdata_q.
        cpu_adr_d   = (state_d == WR || state_d == RD) ?
                      ((state_q == IDLE) ? REQ_ADR : cpu_adr_q) : IDLE_ADR;
        cpu_wdata_d = (state_q == IDLE && state_d == WR) ? REQ_WDATA : cpu_wdata_q;
        rsp_valid_d = state_d == RSP;
        // Going straight from IDLE to RSP only happens for rejected requests.
        rsp_err_d   = state_q == IDLE && state_d == RSP;
        rsp_rdata_d = (state_q == RD && state_d == RSP) ? CPU_RDATA : '0;
    end

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cpu_wr_q    <= 1'b0;
            cpu_rd_q    <= 1'b0;
            cpu_adr_q   <= IDLE_ADR;
            cpu_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cpu_wr_q    <= cpu_wr_d;
            cpu_rd_q    <= cpu_rd_d;
            cpu_adr_q   <= cpu_adr_d;
            cpu_wdata_q <= cpu_wdata_d;
        end
    end

    assign REQ_READY = req_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign CPU_WR    = cpu_wr_q;
    assign CPU_RD    = cpu_rd_q;
    assign CPU_ADR   = cpu_adr_q;
    assign CPU_WDATA = cpu_wdata_q;

endmodule
